turn_stalk_conditioner: RTL and testbench



---
 rtl/turn_stalk_conditioner.sv | 154 +++++++++++++++
 tb/tb_turn_stalk_conditioner.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/turn_stalk_conditioner.sv
// Turn-stalk conditioner: synchronizes and debounces the raw left/right stalk
// contacts, then runs a hold/comfort/conflict FSM. The FSM drives mutually
// exclusive turn requests for the rear-lamp sequencer.
module turn_stalk_conditioner #(
  parameter int TICK_DIV    = 50000,
  parameter int DEBOUNCE_MS = 20,
  parameter int TAP_MS      = 500,
  parameter int COMFORT_MS  = 3000
) (
  input  logic clock,
  input  logic reset,
  input  logic stalk_left_raw,
  input  logic stalk_right_raw,
  output logic sign_left,
  output logic sign_right,
  output logic comfort_active,
  output logic conflict
);

  localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DEB_W   = $clog2(DEBOUNCE_MS + 1);
  localparam int TMAX    = (TAP_MS > COMFORT_MS) ? TAP_MS : COMFORT_MS;
  localparam int TIMER_W = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    LEFT_HOLD,
    LEFT_COMFORT,
    RIGHT_HOLD,
    RIGHT_COMFORT,
    CONFLICT
  } state_t;

  logic [TICK_W-1:0]  tick_cnt_reg;
  logic               tick;
  logic [1:0]         raw;
  logic [1:0]         deb;
  logic               dl;
  logic               dr;
  state_t             state_reg;
  state_t             state_next;
  logic [TIMER_W-1:0] timer_reg;

  assign raw  = {stalk_right_raw, stalk_left_raw};
  assign dl   = deb[0];
  assign dr   = deb[1];
  assign tick = (tick_cnt_reg == TICK_W'(TICK_DIV - 1));

  // 1 ms tick generator: counts 0..TICK_DIV-1 and wraps on the tick clock
  always_ff @(posedge clock or posedge reset) begin
    if (reset)     tick_cnt_reg <= '0;
    else if (tick) tick_cnt_reg <= '0;
    else           tick_cnt_reg <= tick_cnt_reg + 1'b1;
  end

  // One synchronizer + debouncer per contact (bit 0 = left, bit 1 = right)
  for (genvar gi = 0; gi < 2; gi++) begin : g_deb
    logic             sync1_reg;
    logic             sync2_reg;
    logic             deb_reg;
    logic [DEB_W-1:0] cnt_reg;

    // Two-flop sync, then flip the debounced level after DEBOUNCE_MS ticks of disagreement
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        sync1_reg <= 1'b0;
        sync2_reg <= 1'b0;
        deb_reg   <= 1'b0;
        cnt_reg   <= '0;
      end else begin
        sync1_reg <= raw[gi];
        sync2_reg <= sync1_reg;
        if (sync2_reg == deb_reg) begin
          cnt_reg <= '0;
        end else if (tick) begin
          if (cnt_reg == DEB_W'(DEBOUNCE_MS - 1)) begin
            deb_reg <= sync2_reg;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end
    end

    assign deb[gi] = deb_reg;
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Shared timer: cleared on every state entry, counts ticks, saturates at TMAX
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                   timer_reg <= '0;
    else if (state_next != state_reg)            timer_reg <= '0;
    else if (tick && timer_reg != TIMER_W'(TMAX)) timer_reg <= timer_reg + 1'b1;
  end

  // Next-state logic; an opposite contact or both contacts always win over timeouts
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (dl && dr)  state_next = CONFLICT;
        else if (dl)   state_next = LEFT_HOLD;
        else if (dr)   state_next = RIGHT_HOLD;
      end
      LEFT_HOLD: begin
        if (dr)        state_next = CONFLICT;
        else if (!dl)  state_next = (timer_reg < TIMER_W'(TAP_MS)) ? LEFT_COMFORT : IDLE;
      end
      LEFT_COMFORT: begin
        if (dl && dr)  state_next = CONFLICT;
        else if (dl)   state_next = LEFT_HOLD;
        else if (dr)   state_next = RIGHT_HOLD;
        else if (timer_reg == TIMER_W'(COMFORT_MS)) state_next = IDLE;
      end
      RIGHT_HOLD: begin
        if (dl)        state_next = CONFLICT;
        else if (!dr)  state_next = (timer_reg < TIMER_W'(TAP_MS)) ? RIGHT_COMFORT : IDLE;
      end
      RIGHT_COMFORT: begin
        if (dl && dr)  state_next = CONFLICT;
        else if (dr)   state_next = RIGHT_HOLD;
        else if (dl)   state_next = LEFT_HOLD;
        else if (timer_reg == TIMER_W'(COMFORT_MS)) state_next = IDLE;
      end
      CONFLICT: begin
        if (!dl && !dr) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode from the registered state only, so requests never glitch
  always_comb begin
    sign_left      = 1'b0;
    sign_right     = 1'b0;
    comfort_active = 1'b0;
    conflict       = 1'b0;
    case (state_reg)
      LEFT_HOLD:     sign_left = 1'b1;
      LEFT_COMFORT:  begin sign_left = 1'b1; comfort_active = 1'b1; end
      RIGHT_HOLD:    sign_right = 1'b1;
      RIGHT_COMFORT: begin sign_right = 1'b1; comfort_active = 1'b1; end
      CONFLICT:      conflict = 1'b1;
      default:       ;
    endcase
  end

endmodule

// File: tb/tb_turn_stalk_conditioner.sv
// Bench for turn_stalk_conditioner with small timing parameters (1 tick = 4 clocks).
// Expected output-vector changes {sign_left, sign_right, comfort_active, conflict}
// are queued with a cycle window as stimulus is driven, and popped by a monitor
// whenever the DUT outputs change.
module tb_turn_stalk_conditioner;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic stalk_left_raw = 1'b0;
  logic stalk_right_raw = 1'b0;
  logic sign_left, sign_right, comfort_active, conflict;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    string      tag;
    logic [3:0] vec;
    int         lo;
    int         hi;
    bit         rel;   // window relative to the previous observed change
  } exp_t;

  exp_t sb[$];

  turn_stalk_conditioner #(
    .TICK_DIV(4), .DEBOUNCE_MS(3), .TAP_MS(10), .COMFORT_MS(20)
  ) dut (
    .clock(clock),
    .reset(reset),
    .stalk_left_raw(stalk_left_raw),
    .stalk_right_raw(stalk_right_raw),
    .sign_left(sign_left),
    .sign_right(sign_right),
    .comfort_active(comfort_active),
    .conflict(conflict)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [3:0] outs();
    return {sign_left, sign_right, comfort_active, conflict};
  endfunction

  task automatic push(input string tag, input logic [3:0] vec, input int lo, input int hi, input bit rel);
    exp_t e;
    e.tag = tag; e.vec = vec; e.lo = lo; e.hi = hi; e.rel = rel;
    sb.push_back(e);
  endtask

  task automatic check_vec(input string tag, input logic [3:0] expv);
    logic [3:0] o;
    o = outs();
    checks++;
    assert (o === expv) else begin
      errors++;
      $error("FAIL %s: outputs=%b required %b at cyc %0d", tag, o, expv, cyc);
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    checks++;
    assert (sb.size() === 0) else begin
      errors++;
      $error("FAIL %s: %0d expected changes still pending after %0d clocks, required 0", tag, sb.size(), budget);
    end
    sb.delete();
  endtask

  // Monitor: every output change must match the head of the scoreboard
  initial begin
    logic [3:0] last_vec;
    logic [3:0] v;
    int last_evt;
    int lo, hi;
    exp_t e;
    last_vec = 4'b0000;
    last_evt = 0;
    forever begin
      @(negedge clock);
      v = outs();
      if (v !== last_vec) begin
        checks++;
        if (sb.size() == 0) begin
          assert (v === last_vec) else begin
            errors++;
            $error("FAIL unexpected_change: outputs=%b at cyc %0d, required unchanged %b", v, cyc, last_vec);
          end
        end else begin
          e = sb.pop_front();
          lo = e.rel ? last_evt + e.lo : e.lo;
          hi = e.rel ? last_evt + e.hi : e.hi;
          assert (v === e.vec && cyc >= lo && cyc <= hi) else begin
            errors++;
            $error("FAIL %s: outputs=%b at cyc %0d, required %b in cyc [%0d,%0d]", e.tag, v, cyc, e.vec, lo, hi);
          end
        end
        checks++;
        assert (!(v[3] && v[2])) else begin
          errors++;
          $error("FAIL exclusive: sign_left=%b sign_right=%b, required not both 1", v[3], v[2]);
        end
        last_vec = v;
        last_evt = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by 200000 ns, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;

    // Reset and quiet inputs
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check_vec("reset_state", 4'b0000);
    repeat (200) @(negedge clock);
    check_vec("idle_200", 4'b0000);

    // Long left hold with a one-clock reset in the middle
    @(negedge clock); stalk_left_raw = 1'b1; c = cyc;
    push("left_press", 4'b1000, c + 10, c + 17, 1'b0);
    drain("left_press_drain", 40);
    repeat (20) @(negedge clock);
    #2; reset = 1'b1; c = cyc;
    push("reset_drop", 4'b0000, c, c + 1, 1'b0);
    push("re_debounce", 4'b1000, c + 10, c + 22, 1'b0);
    #1; check_vec("async_drop", 4'b0000);
    @(negedge clock); #2; reset = 1'b0;
    drain("reset_drain", 40);
    repeat (200) @(negedge clock);
    stalk_left_raw = 1'b0; c = cyc;
    push("left_long_release", 4'b0000, c + 10, c + 17, 1'b0);
    drain("left_release_drain", 40);

    // Right tap of 6 ticks -> comfort for 20 ticks
    @(negedge clock); stalk_right_raw = 1'b1; c = cyc;
    push("right_press", 4'b0100, c + 10, c + 17, 1'b0);
    repeat (24) @(negedge clock);
    stalk_right_raw = 1'b0; c = cyc;
    push("right_comfort", 4'b0110, c + 10, c + 17, 1'b0);
    push("right_comfort_end", 4'b0000, 76, 84, 1'b1);
    drain("right_tap_drain", 200);

    // Bounce: toggle every tick for 10 ticks, settle low
    for (int i = 0; i < 10; i++) begin
      stalk_left_raw = ~stalk_left_raw;
      repeat (4) @(negedge clock);
    end
    stalk_left_raw = 1'b0;
    repeat (60) @(negedge clock);
    check_vec("bounce_quiet", 4'b0000);

    // Conflict: left held then right pressed
    stalk_left_raw = 1'b1; c = cyc;
    push("conf_left", 4'b1000, c + 10, c + 17, 1'b0);
    drain("conf_left_drain", 40);
    repeat (20) @(negedge clock);
    stalk_right_raw = 1'b1; c = cyc;
    push("conflict_enter", 4'b0001, c + 10, c + 17, 1'b0);
    drain("conflict_drain", 40);
    repeat (10) @(negedge clock);
    stalk_right_raw = 1'b0;
    repeat (40) @(negedge clock);
    check_vec("conflict_hold", 4'b0001);
    stalk_left_raw = 1'b0; c = cyc;
    push("conflict_exit", 4'b0000, c + 10, c + 17, 1'b0);
    drain("conflict_exit_drain", 40);

    // Left tap into comfort, then a right tap cancels it
    repeat (10) @(negedge clock);
    stalk_left_raw = 1'b1; c = cyc;
    push("ltap_press", 4'b1000, c + 10, c + 17, 1'b0);
    repeat (16) @(negedge clock);
    stalk_left_raw = 1'b0; c = cyc;
    push("left_comfort", 4'b1010, c + 10, c + 17, 1'b0);
    drain("left_comfort_drain", 60);
    stalk_right_raw = 1'b1; c = cyc;
    push("cancel_to_right", 4'b0100, c + 10, c + 17, 1'b0);
    repeat (20) @(negedge clock);
    stalk_right_raw = 1'b0; c = cyc;
    push("right_comfort2", 4'b0110, c + 10, c + 17, 1'b0);
    push("right_comfort2_end", 4'b0000, 76, 84, 1'b1);
    drain("cancel_drain", 200);
    check_vec("final_idle", 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
